// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and window type for the conv window master.
package conv_pkg;
   localparam int K  = 5;
   localparam int DW = 16;
   localparam int AW = 16;

   typedef logic [K*K*DW-1:0] window_t;

   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_GAP, WIN_OUT, RES_WAIT, WR_REQ, WR_GAP, NEXT, DONE
   } state_t;
endpackage

// File: rtl/conv_window_master_if.sv
// Memory request port plus window/result handshakes between master, RAM and datapath.
interface conv_window_master_if;
   import conv_pkg::*;

   logic          mem_enable;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [AW-1:0] mem_offset;
   logic [DW-1:0] mem_wdata;
   window_t       mem_rdata;
   logic          mem_finish;
   logic          win_valid;
   logic          win_ready;
   window_t       win_data;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;

   modport master (
      output mem_enable, mem_write, mem_address, mem_offset, mem_wdata,
      output win_valid, win_data, res_ready,
      input  mem_rdata, mem_finish, win_ready, res_valid, res_data
   );

   modport slave (
      input  mem_enable, mem_write, mem_address, mem_offset, mem_wdata,
      input  win_valid, win_data, res_ready,
      output mem_rdata, mem_finish, win_ready, res_valid, res_data
   );
endinterface

// File: rtl/scan_addr_gen.sv
// Raster row/col counters with running row-base accumulators for read and write addresses.
// Addresses are combinational from registered state; advances one pixel per i_step.
module scan_addr_gen
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_init,
   input  logic          i_step,
   input  logic [AW-1:0] i_img_base,
   input  logic [AW-1:0] i_img_width,
   input  logic [AW-1:0] i_out_dim,
   input  logic [AW-1:0] i_res_base,
   output logic [AW-1:0] o_rd_addr,
   output logic [AW-1:0] o_wr_addr,
   output logic [AW-1:0] o_offset,
   output logic          o_last
);
   logic [AW-1:0] r_row;
   logic [AW-1:0] r_col;
   logic [AW-1:0] r_dim;
   logic [AW-1:0] r_width;
   logic [AW-1:0] r_rd_row;
   logic [AW-1:0] r_wr_row;
   logic          w_col_wrap;

   assign w_col_wrap = (r_col == r_dim - AW'(1));

   // Row bases replace row*stride multiplies; all sums wrap mod 2^AW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row    <= '0;
         r_col    <= '0;
         r_dim    <= '0;
         r_width  <= '0;
         r_rd_row <= '0;
         r_wr_row <= '0;
      end else if (i_init) begin
         r_row    <= '0;
         r_col    <= '0;
         r_dim    <= i_out_dim;
         r_width  <= i_img_width;
         r_rd_row <= i_img_base;
         r_wr_row <= i_res_base;
      end else if (i_step) begin
         if (w_col_wrap) begin
            r_col    <= '0;
            r_row    <= r_row + AW'(1);
            r_rd_row <= r_rd_row + r_width;
            r_wr_row <= r_wr_row + r_dim;
         end else begin
            r_col <= r_col + AW'(1);
         end
      end
   end

   assign o_rd_addr = r_rd_row + r_col;
   assign o_wr_addr = r_wr_row + r_col;
   assign o_offset  = r_width;
   assign o_last    = w_col_wrap && (r_row == r_dim - AW'(1));
endmodule

// File: rtl/conv_window_master.sv
// Sole memory master for a conv layer: read 5x5 window, hand to datapath, write result; 7 cycles/pixel minimum.
// Waits indefinitely on win_ready/res_valid; memory requests abort after TIMEOUT cycles with sticky err.
module conv_window_master
   import conv_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        img_base,
   input  logic [AW-1:0]        img_width,
   input  logic [AW-1:0]        out_dim,
   input  logic [AW-1:0]        res_base,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   conv_window_master_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        r_state;
   state_t        w_next;
   logic [TW-1:0] r_tmo;
   logic          r_err;
   window_t       r_win;
   logic [DW-1:0] r_wdata;
   logic          w_accept;
   logic          w_req;
   logic          w_tmo_hit;
   logic          w_last;
   logic [AW-1:0] w_rd_addr;
   logic [AW-1:0] w_wr_addr;
   logic [AW-1:0] w_offset;

   assign w_accept  = (r_state == IDLE) && start;
   assign w_req     = (r_state == RD_REQ) || (r_state == WR_REQ);
   assign w_tmo_hit = w_req && !bus.mem_finish && (r_tmo == TW'(TIMEOUT - 1));

   scan_addr_gen u_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_init      (w_accept),
      .i_step      (r_state == NEXT),
      .i_img_base  (img_base),
      .i_img_width (img_width),
      .i_out_dim   (out_dim),
      .i_res_base  (res_base),
      .o_rd_addr   (w_rd_addr),
      .o_wr_addr   (w_wr_addr),
      .o_offset    (w_offset),
      .o_last      (w_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (start) w_next = (out_dim == '0) ? DONE : RD_REQ;
         RD_REQ:   if (bus.mem_finish) w_next = RD_GAP;
                   else if (w_tmo_hit) w_next = DONE;
         RD_GAP:   w_next = WIN_OUT;
         WIN_OUT:  if (bus.win_ready) w_next = RES_WAIT;
         RES_WAIT: if (bus.res_valid) w_next = WR_REQ;
         WR_REQ:   if (bus.mem_finish) w_next = WR_GAP;
                   else if (w_tmo_hit) w_next = DONE;
         WR_GAP:   w_next = NEXT;
         NEXT:     w_next = w_last ? DONE : RD_REQ;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Timeout counter is zero outside request states, so every request starts counting from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tmo   <= '0;
         r_err   <= 1'b0;
         r_win   <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         r_tmo   <= (w_req && (w_next == r_state)) ? r_tmo + TW'(1) : '0;
         if (w_accept)
            r_err <= 1'b0;
         else if (w_tmo_hit)
            r_err <= 1'b1;
         if ((r_state == RD_REQ) && bus.mem_finish)
            r_win <= bus.mem_rdata;
         if ((r_state == RES_WAIT) && bus.res_valid)
            r_wdata <= bus.res_data;
      end
   end

   assign bus.mem_enable  = w_req;
   assign bus.mem_write   = (r_state == WR_REQ);
   assign bus.mem_address = (r_state == RD_REQ) ? w_rd_addr :
                            (r_state == WR_REQ) ? w_wr_addr : '0;
   assign bus.mem_offset  = w_offset;
   assign bus.mem_wdata   = r_wdata;
   assign bus.win_valid   = (r_state == WIN_OUT);
   assign bus.win_data    = r_win;
   assign bus.res_ready   = (r_state == RES_WAIT);
   assign busy            = (r_state != IDLE) && (r_state != DONE);
   assign done            = (r_state == DONE);
   assign err             = r_err;
endmodule

// File: tb/tb_conv_window_master.sv
// Scoreboarded bench: RAM and datapath models driven at negedge, expectations from a plain-arithmetic model.
module tb_conv_window_master;
   import conv_pkg::*;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] img_base = '0;
   logic [AW-1:0] img_width = '0;
   logic [AW-1:0] out_dim = '0;
   logic [AW-1:0] res_base = '0;
   logic          busy, done, err;

   conv_window_master_if bus();

   conv_window_master #(.TIMEOUT(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .img_base  (img_base),
      .img_width (img_width),
      .out_dim   (out_dim),
      .res_base  (res_base),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] ref1 [0:15];
   logic [AW-1:0] exp_rd [$];
   wr_t           exp_wr [$];
   window_t       exp_win [$];

   int checks = 0;
   int errors = 0;
   int hang_rd = 0;
   bit hang_wr = 1'b0;
   int win_stall = 0;
   int res_lat = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int en_run = 0;
   int en_max = 0;
   int done_cnt = 0;
   logic [AW-1:0] exp_offset = '0;

   bit            ram_seen = 1'b0;
   window_t       ram_w;
   logic [AW-1:0] ram_a;
   wr_t           ram_e;
   int            stall_cnt = 0;
   bit            win_seen = 1'b0;
   bit            win_unstable = 1'b0;
   window_t       win_hold;
   bit            res_pend = 1'b0;
   bit            res_armed = 1'b0;
   int            res_cnt = 0;
   logic [DW-1:0] res_sum;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_win(input string name, input window_t act, input window_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_quiet(input string pfx);
      chk({pfx, "_mem_enable"}, bus.mem_enable, 0);
      chk({pfx, "_mem_write"}, bus.mem_write, 0);
      chk({pfx, "_mem_address"}, bus.mem_address, 0);
      chk({pfx, "_mem_offset"}, bus.mem_offset, 0);
      chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({pfx, "_win_valid"}, bus.win_valid, 0);
      chk({pfx, "_win_data_zero"}, bus.win_data == '0, 1);
      chk({pfx, "_res_ready"}, bus.res_ready, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_err"}, err, 0);
   endtask

   // Reference: every output pixel's read address, window and window-sum write, by direct arithmetic.
   task automatic build_exp(input logic [AW-1:0] ib, iw, od, rb);
      window_t       w;
      logic [DW-1:0] s;
      logic [AW-1:0] a;
      wr_t           e;
      exp_rd.delete();
      exp_wr.delete();
      exp_win.delete();
      for (int row = 0; row < int'(od); row++) begin
         for (int col = 0; col < int'(od); col++) begin
            exp_rd.push_back(AW'(int'(ib) + row * int'(iw) + col));
            s = '0;
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K; c++) begin
                  a = AW'(int'(ib) + (row + r) * int'(iw) + col + c);
                  w[(r*K+c)*DW +: DW] = mem[a];
                  s = s + mem[a];
               end
            end
            exp_win.push_back(w);
            e.addr = AW'(int'(rb) + row * int'(od) + col);
            e.data = s;
            exp_wr.push_back(e);
         end
      end
   endtask

   task automatic run_layer(input logic [AW-1:0] ib, iw, od, rb,
                            input int hang, input int stall, input int rlat, input bit poke);
      int cyc;
      int d0;
      build_exp(ib, iw, od, rb);
      hang_rd = hang; win_stall = stall; res_lat = rlat;
      rd_cnt = 0; wr_cnt = 0; en_max = 0; exp_offset = iw; d0 = done_cnt;
      @(negedge clk);
      img_base = ib; img_width = iw; out_dim = od; res_base = rb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      img_base = AW'($urandom); img_width = AW'($urandom);
      out_dim = AW'($urandom); res_base = AW'($urandom);
      chk("err_clear_on_start", err, 0);
      if (od != 0) chk("busy_after_start", busy, 1);
      cyc = 1;
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         start = (poke && cyc == 20);
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      chk("err_at_done", err, hang != 0);
      chk("enable_low_at_done", bus.mem_enable, 0);
      if (od == 0) begin
         chk("zero_dim_latency", cyc <= 2, 1);
         chk("zero_dim_no_enable", en_max, 0);
      end else begin
         chk("enable_cycles_max", en_max, (hang != 0) ? 64 : 1);
      end
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_single_pulse", done, 0);
      chk("done_count", done_cnt - d0, 1);
      chk("err_sticky", err, hang != 0);
      if (hang == 0) begin
         chk("read_count", rd_cnt, int'(od) * int'(od));
         chk("write_count", wr_cnt, int'(od) * int'(od));
         chk("rd_queue_drained", exp_rd.size(), 0);
         chk("wr_queue_drained", exp_wr.size(), 0);
         chk("win_queue_drained", exp_win.size(), 0);
      end else begin
         chk("reads_before_abort", rd_cnt, hang);
         chk("writes_before_abort", wr_cnt, hang - 1);
      end
      hang_rd = 0;
   endtask

   // RAM model: services each request once, compares it to the scoreboard, finishes unless told to hang.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.mem_enable) begin
            en_run++;
            if (en_run > en_max) en_max = en_run;
         end else begin
            en_run = 0;
         end
         if (!bus.mem_enable) begin
            bus.mem_finish = 1'b0;
            ram_seen = 1'b0;
         end else if (!ram_seen) begin
            ram_seen = 1'b1;
            if (bus.mem_write) begin
               wr_cnt++;
               chk("wr_expected", exp_wr.size() != 0, 1);
               if (exp_wr.size() != 0) begin
                  ram_e = exp_wr.pop_front();
                  chk("wr_addr", bus.mem_address, ram_e.addr);
                  chk("wr_data", bus.mem_wdata, ram_e.data);
               end
               if (!hang_wr) begin
                  mem[bus.mem_address] = bus.mem_wdata;
                  bus.mem_finish = 1'b1;
               end
            end else begin
               rd_cnt++;
               chk("rd_expected", exp_rd.size() != 0, 1);
               if (exp_rd.size() != 0) chk("rd_addr", bus.mem_address, exp_rd.pop_front());
               chk("rd_offset", bus.mem_offset, exp_offset);
               if (rd_cnt != hang_rd) begin
                  for (int r = 0; r < K; r++) begin
                     for (int c = 0; c < K; c++) begin
                        ram_a = bus.mem_address + AW'(r) * bus.mem_offset + AW'(c);
                        ram_w[(r*K+c)*DW +: DW] = mem[ram_a];
                     end
                  end
                  bus.mem_rdata = ram_w;
                  bus.mem_finish = 1'b1;
               end
            end
         end
      end
   end

   // Datapath model: optional win_ready stall, returns the window sum after res_lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (res_armed) begin
            bus.res_valid = 1'b0;
            res_armed = 1'b0;
         end
         if (res_pend) begin
            if (res_cnt > 0) res_cnt--;
            else begin
               bus.res_valid = 1'b1;
               bus.res_data = res_sum;
               res_pend = 1'b0;
            end
         end
         if (bus.res_valid && bus.res_ready) res_armed = 1'b1;
         if (!bus.win_valid) begin
            bus.win_ready = 1'b0;
            stall_cnt = 0;
            win_seen = 1'b0;
         end else begin
            if (!win_seen) begin
               win_seen = 1'b1;
               win_hold = bus.win_data;
               win_unstable = 1'b0;
            end else if (bus.win_data !== win_hold) begin
               win_unstable = 1'b1;
            end
            if (stall_cnt < win_stall) stall_cnt++;
            else bus.win_ready = 1'b1;
            if (bus.win_ready) begin
               chk("win_stable", win_unstable, 0);
               chk("win_expected", exp_win.size() != 0, 1);
               if (exp_win.size() != 0) chk_win("win_data", bus.win_data, exp_win.pop_front());
               res_sum = '0;
               for (int i = 0; i < K*K; i++) res_sum = res_sum + bus.win_data[i*DW +: DW];
               res_pend = 1'b1;
               res_cnt = res_lat;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   end

   initial begin
      int cyc;
      int d0;
      bus.mem_finish = 1'b0;
      bus.mem_rdata  = '0;
      bus.win_ready  = 1'b0;
      bus.res_valid  = 1'b0;
      bus.res_data   = '0;
      for (int i = 0; i < 65536; i++) mem[i] = DW'(i);
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      rst_n = 1'b1;

      // 8-wide image at 0, 4x4 output to 100..115, zero-wait environment.
      run_layer(16'd0, 16'd8, 16'd4, 16'd100, 0, 0, 0, 1'b0);
      chk("result_mem100", mem[100], 450);
      chk("result_mem115", mem[115], 1125);
      for (int i = 0; i < 16; i++) begin
         ref1[i] = mem[100 + i];
         mem[100 + i] = '0;
      end

      // Same layer with window stall, late results and a start pulse while busy.
      run_layer(16'd0, 16'd8, 16'd4, 16'd100, 0, 10, 5, 1'b1);
      for (int i = 0; i < 16; i++) chk("stall_result_same", mem[100 + i], ref1[i]);

      // Third read never finishes.
      run_layer(16'd0, 16'd8, 16'd4, 16'd100, 3, 0, 0, 1'b0);

      // Empty layer; also clears the sticky err from the aborted run.
      run_layer(16'd0, 16'd8, 16'd0, 16'd100, 0, 0, 0, 1'b0);

      // Reset while a write request is outstanding.
      hang_wr = 1'b1;
      build_exp(16'd0, 16'd8, 16'd3, 16'd200);
      exp_offset = 16'd8;
      @(negedge clk);
      img_base = 16'd0; img_width = 16'd8; out_dim = 16'd3; res_base = 16'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(bus.mem_enable && bus.mem_write) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_wr_req", bus.mem_enable && bus.mem_write, 1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1 chk_quiet("mid_reset");
      repeat (3) @(negedge clk);
      chk("no_done_on_reset", done_cnt - d0, 0);
      rst_n = 1'b1;
      hang_wr = 1'b0;
      run_layer(16'd0, 16'd8, 16'd3, 16'd200, 0, 0, 0, 1'b0);

      // Random contents: address wrap past 2^AW, then random geometries and handshake delays.
      for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
      for (int i = 65472; i < 65536; i++) mem[i] = DW'($urandom);
      run_layer(16'hFFF0, 16'd6, 16'd2, 16'd30000, 0, 1, 2, 1'b0);
      for (int t = 0; t < 4; t++) begin
         logic [AW-1:0] d, w, b;
         d = AW'($urandom_range(1, 4));
         w = d + AW'($urandom_range(4, 7));
         b = AW'($urandom_range(0, 3000));
         run_layer(b, w, d, AW'(30100 + t * 40), 0, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 6)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
